pll2_reconfig_ctrl: RTL and testbench

//  Sequences Avalon-MM writes into the altera_pll_reconfig bridge feeding the reconfigurable video PLL.

---
 rtl/pll2_reconfig_pkg.sv | 45 ++++
 rtl/pll2_avm_wr.sv | 37 +++
 rtl/pll2_reconfig_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pll2_reconfig_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll2_reconfig_pkg.sv
// Shared types and constants for the video PLL reconfiguration sequencer.
package pll2_reconfig_pkg;

    // Sequencer states: one write state per reconfig register touched.
    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StMode,
        StMcnt,
        StKfrac,
        StC0,
        StStart,
        StRelock
    } state_e;

    // altera_pll_reconfig register map.
    localparam logic [5:0] AddrMode   = 6'd0;
    localparam logic [5:0] AddrStatus = 6'd1;
    localparam logic [5:0] AddrStart  = 6'd2;
    localparam logic [5:0] AddrN      = 6'd3;
    localparam logic [5:0] AddrM      = 6'd4;
    localparam logic [5:0] AddrC      = 6'd5;
    localparam logic [5:0] AddrK      = 6'd7;

    // Counter-word field offsets: {9'b0, sel[4:0], odd, bypass, hi[7:0], lo[7:0]}.
    localparam int unsigned CntHiloLsb   = 0;
    localparam int unsigned CntBypassBit = 16;
    localparam int unsigned CntOddBit    = 17;
    localparam int unsigned CntSelLsb    = 18;

    // Assemble a counter-setting word for the M or C registers.
    function automatic logic [31:0] cnt_word(input logic [4:0]  sel,
                                             input logic        odd,
                                             input logic        bypass,
                                             input logic [15:0] hilo);
        logic [31:0] word;
        word                      = '0;
        word[CntSelLsb +: 5]      = sel;
        word[CntOddBit]           = odd;
        word[CntBypassBit]        = bypass;
        word[CntHiloLsb +: 16]    = hilo;
        return word;
    endfunction

endpackage

// File: rtl/pll2_avm_wr.sv
// Single-write Avalon-MM master: launches one write per request and holds
// address/data/write stable until the slave drops waitrequest.
module pll2_avm_wr (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [5:0]  addr,
    input  logic [31:0] data,
    output logic        ack,
    output logic [5:0]  cfg_address,
    output logic [31:0] cfg_writedata,
    output logic        cfg_write,
    input  logic        cfg_waitrequest
);

    // Launch on request when idle; retire on the first edge without waitrequest.
    // A request is never sampled in the retiring cycle, so writes are never back-to-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_write     <= 1'b0;
            cfg_address   <= '0;
            cfg_writedata <= '0;
        end else if (cfg_write) begin
            if (!cfg_waitrequest) begin
                cfg_write <= 1'b0;
            end
        end else if (req) begin
            cfg_write     <= 1'b1;
            cfg_address   <= addr;
            cfg_writedata <= data;
        end
    end

    // High in the cycle whose closing edge completes the transfer.
    assign ack = cfg_write & ~cfg_waitrequest;

endmodule

// File: rtl/pll2_reconfig_ctrl.sv
// Retunes the video PLL between NTSC and PAL profiles by sequencing writes
// into the altera_pll_reconfig bridge, then waiting for the PLL to relock.
module pll2_reconfig_ctrl
    import pll2_reconfig_pkg::*;
#(
    parameter logic [15:0] M_HILO       = 16'h0404,
    parameter logic [15:0] C0_HILO      = 16'h0504,
    parameter logic [31:0] K_NTSC       = 32'd3274482981,
    parameter logic [31:0] K_PAL        = 32'd4029452419,
    parameter logic [23:0] LOCK_TIMEOUT = 24'd5000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pal_mode,
    input  logic        pll_locked,
    output logic [5:0]  cfg_address,
    output logic [31:0] cfg_writedata,
    output logic        cfg_write,
    input  logic        cfg_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        cfg_error,
    output logic        cur_pal
);

    logic        pal_meta_q, pal_s_q;
    logic        lock_meta_q, lock_s_q, lock_prev_q;
    logic        lock_rise;

    state_e      state_q;
    logic        tgt_q;
    logic [23:0] cnt_q;

    logic        wr_req;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;

    // Two-flop synchronisers for the async inputs, plus a delayed copy of lock for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pal_meta_q  <= 1'b0;
            pal_s_q     <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            lock_prev_q <= 1'b0;
        end else begin
            pal_meta_q  <= pal_mode;
            pal_s_q     <= pal_meta_q;
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
            lock_prev_q <= lock_s_q;
        end
    end

    // Only a fresh 0->1 transition counts as relock; a level already high does not.
    assign lock_rise = lock_s_q & ~lock_prev_q;

    // Per-state write request; address and data follow the current write state.
    always_comb begin
        wr_req  = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            StMode: begin
                wr_addr = AddrMode;
                wr_data = 32'd0;
            end
            StMcnt: begin
                wr_addr = AddrM;
                wr_data = cnt_word(5'd0, 1'b0, 1'b0, M_HILO);
            end
            StKfrac: begin
                wr_addr = AddrK;
                wr_data = tgt_q ? K_PAL : K_NTSC;
            end
            StC0: begin
                wr_addr = AddrC;
                wr_data = cnt_word(5'd0, 1'b1, 1'b0, C0_HILO);
            end
            StStart: begin
                wr_addr = AddrStart;
                wr_data = 32'd1;
            end
            default: begin
                wr_req = 1'b0;
            end
        endcase
    end

    pll2_avm_wr u_avm_wr (
        .clk             (clk),
        .reset           (reset),
        .req             (wr_req),
        .addr            (wr_addr),
        .data            (wr_data),
        .ack             (wr_ack),
        .cfg_address     (cfg_address),
        .cfg_writedata   (cfg_writedata),
        .cfg_write       (cfg_write),
        .cfg_waitrequest (cfg_waitrequest)
    );

    // Sequencer FSM with registered status outputs and the saturating relock timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StInit;
            tgt_q     <= 1'b0;
            cnt_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_error <= 1'b0;
            cur_pal   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StInit: begin
                    if (lock_s_q) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    // Target is frozen here; later pal_mode changes wait for the next IDLE.
                    if (pal_s_q != cur_pal) begin
                        tgt_q   <= pal_s_q;
                        busy    <= 1'b1;
                        state_q <= StMode;
                    end
                end
                StMode: begin
                    if (wr_ack) state_q <= StMcnt;
                end
                StMcnt: begin
                    if (wr_ack) state_q <= StKfrac;
                end
                StKfrac: begin
                    if (wr_ack) state_q <= StC0;
                end
                StC0: begin
                    if (wr_ack) state_q <= StStart;
                end
                StStart: begin
                    if (wr_ack) begin
                        cnt_q   <= '0;
                        state_q <= StRelock;
                    end
                end
                StRelock: begin
                    if (lock_rise) begin
                        cur_pal <= tgt_q;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_q == LOCK_TIMEOUT - 24'd1) begin
                        cfg_error <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                default: begin
                    state_q <= StInit;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll2_reconfig_ctrl.sv
// Directed bench for pll2_reconfig_ctrl: table of profile-switch vectors plus
// hand-written sequences for timeout and mid-write reset.
module tb_pll2_reconfig_ctrl;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic pal;     // requested profile
        int   ws;      // waitrequest cycles per write
        bit   toggle;  // glitch pal_mode around the KFRAC write
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pal_mode;
    logic        pll_locked;
    logic [5:0]  cfg_address;
    logic [31:0] cfg_writedata;
    logic        cfg_write;
    logic        cfg_waitrequest;
    logic        busy;
    logic        done;
    logic        cfg_error;
    logic        cur_pal;

    int n_tests = 0;
    int n_fail  = 0;

    wr_t  exp_seq[2][5];
    vec_t vecs[4];

    always #5 clk = ~clk;

    pll2_reconfig_ctrl #(
        .LOCK_TIMEOUT (24'd100)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pal_mode        (pal_mode),
        .pll_locked      (pll_locked),
        .cfg_address     (cfg_address),
        .cfg_writedata   (cfg_writedata),
        .cfg_write       (cfg_write),
        .cfg_waitrequest (cfg_waitrequest),
        .busy            (busy),
        .done            (done),
        .cfg_error       (cfg_error),
        .cur_pal         (cur_pal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge with cfg_write high.
    task automatic wait_write(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cfg_write === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Acts as the bridge for one full 5-write sequence and checks every transfer.
    task automatic run_writes(input logic pal, input int ws, input bit toggle);
        bit          ok;
        int          bad;
        logic [5:0]  a;
        logic [31:0] d;
        for (int idx = 0; idx < 5; idx++) begin
            cfg_waitrequest = (ws != 0);
            wait_write(ok);
            if (!ok) begin
                chk($sformatf("wr%0d_seen", idx), 32'(ok), 32'd1);
                return;
            end
            a = cfg_address;
            d = cfg_writedata;
            chk($sformatf("wr%0d_addr", idx), 32'(a), 32'(exp_seq[int'(pal)][idx].addr));
            chk($sformatf("wr%0d_data", idx), d, exp_seq[int'(pal)][idx].data);
            // Flip the request before KFRAC launches; the latched target must win.
            if (toggle && idx == 1) pal_mode = ~pal;
            bad = 0;
            repeat (ws) begin
                @(negedge clk);
                if (cfg_write !== 1'b1 || cfg_address !== a || cfg_writedata !== d) bad++;
            end
            if (ws > 0) chk($sformatf("wr%0d_stable", idx), 32'(bad), 32'd0);
            cfg_waitrequest = 1'b0;
            @(negedge clk);
            chk($sformatf("wr%0d_gap", idx), 32'(cfg_write), 32'd0);
            if (toggle && idx == 2) pal_mode = pal;
        end
    endtask

    // Pulses lock low then high and expects a one-cycle done with the new profile.
    task automatic relock(input logic pal);
        bit got;
        pll_locked = 1'b0;
        repeat (3) @(negedge clk);
        pll_locked = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("cur_pal_after_done", 32'(cur_pal), 32'(pal));
        chk("busy_after_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    // Watches for quiet: no write, not busy, for n cycles.
    task automatic expect_quiet(input string name, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (cfg_write !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;

        for (int p = 0; p < 2; p++) begin
            exp_seq[p][0] = '{6'd0, 32'd0};
            exp_seq[p][1] = '{6'd4, 32'h0000_0404};
            exp_seq[p][2] = '{6'd7, (p == 1) ? 32'd4029452419 : 32'd3274482981};
            exp_seq[p][3] = '{6'd5, 32'h0002_0504};
            exp_seq[p][4] = '{6'd2, 32'd1};
        end
        vecs[0] = '{1'b1, 0, 1'b0};
        vecs[1] = '{1'b0, 1, 1'b0};
        vecs[2] = '{1'b1, 3, 1'b1};
        vecs[3] = '{1'b0, 0, 1'b0};

        // Power-on: reset, locked arrives after 10 cycles, NTSC requested.
        reset           = 1'b1;
        pal_mode        = 1'b0;
        pll_locked      = 1'b0;
        cfg_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_write", 32'(cfg_write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(cfg_error), 32'd0);
        chk("rst_cur_pal", 32'(cur_pal), 32'd0);
        chk("rst_addr", 32'(cfg_address), 32'd0);
        chk("rst_data", cfg_writedata, 32'd0);
        repeat (10) @(negedge clk);
        pll_locked = 1'b1;
        expect_quiet("init_no_writes", 12);

        // Table-driven profile switches.
        foreach (vecs[v]) begin
            pal_mode = vecs[v].pal;
            run_writes(vecs[v].pal, vecs[v].ws, vecs[v].toggle);
            relock(vecs[v].pal);
            expect_quiet($sformatf("vec%0d_no_extra_pass", v), 10);
        end

        // Lock never returns: error after 100 cycles in RELOCK, profile kept, retry follows.
        pal_mode = 1'b1;
        run_writes(1'b1, 0, 1'b0);
        pll_locked = 1'b0;
        n = 0;
        chk("to_no_early_error", 32'(cfg_error), 32'd0);
        while (cfg_error !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 32'(n), 32'd100);
        chk("to_error", 32'(cfg_error), 32'd1);
        chk("to_cur_pal", 32'(cur_pal), 32'd0);
        chk("to_busy", 32'(busy), 32'd0);
        cfg_waitrequest = 1'b0;
        wait_write(ok);
        chk("retry_seen", 32'(ok), 32'd1);
        chk("retry_addr", 32'(cfg_address), 32'd0);
        chk("retry_busy", 32'(busy), 32'd1);
        chk("retry_error_sticky", 32'(cfg_error), 32'd1);

        // Reset while MCNT is stalled by waitrequest.
        @(negedge clk);
        cfg_waitrequest = 1'b1;
        wait_write(ok);
        chk("mcnt_addr", 32'(cfg_address), 32'd4);
        @(negedge clk);
        chk("mcnt_held", 32'(cfg_write), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_write", 32'(cfg_write), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_error", 32'(cfg_error), 32'd0);
        chk("rst_mid_cur_pal", 32'(cur_pal), 32'd0);
        chk("rst_mid_addr", 32'(cfg_address), 32'd0);
        @(negedge clk);
        reset           = 1'b0;
        cfg_waitrequest = 1'b0;
        // Unlocked: INIT must hold off even though PAL is requested.
        expect_quiet("init_waits_lock", 20);
        pll_locked = 1'b1;
        wait_write(ok);
        chk("post_rst_seen", 32'(ok), 32'd1);
        chk("post_rst_addr", 32'(cfg_address), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
